// File: rtl/sbs_merge.sv
// sbs_merge: rebuilds a side-by-side line from per-line left/right half streams, replayed one line later.
// Optional SBS_MERGE_BORDER_EN paints BORDER_PX on the two seam columns of replayed lines.
module sbs_merge #(
  parameter int HALF_IMG_W = 32,
  parameter int PX_WIDTH = 24,
  parameter logic [PX_WIDTH-1:0] FILL_PX = '0,
  parameter logic [PX_WIDTH-1:0] BORDER_PX = 'hFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic de_in,
  input  logic h_sync_in,
  input  logic v_sync_in,
  input  logic [PX_WIDTH-1:0] pixel_left,
  input  logic [PX_WIDTH-1:0] pixel_right,
  output logic clk_out,
  output logic de_out,
  output logic h_sync_out,
  output logic v_sync_out,
  output logic [PX_WIDTH-1:0] pixel_out
);
  localparam int AW = $clog2(HALF_IMG_W);
  typedef enum logic [1:0] {S_BLANK, S_FILL, S_PLAY} state_t;
  state_t state;
  logic [PX_WIDTH-1:0] buf_l [HALF_IMG_W];
  logic [PX_WIDTH-1:0] buf_r [HALF_IMG_W];
  logic [PX_WIDTH-1:0] rd_px;
  logic [10:0] col;
  logic [AW:0] wr_cnt;
  logic [AW-1:0] wa;
  logic [1:0] sel;
  logic line_ready, de_rise, de_fall, vs_rise, vs_fall, in_l, in_r, play, hit, seam;
  assign clk_out = clk;
  assign de_rise = de_in && !de_out;
  assign de_fall = !de_in && de_out;
  assign vs_rise = v_sync_in && !v_sync_out;
  assign vs_fall = !v_sync_in && v_sync_out;
  assign in_l = col < 11'(HALF_IMG_W);
  assign in_r = !in_l && col < 11'(2 * HALF_IMG_W);
  assign wa = AW'(col - 11'(HALF_IMG_W));
  // the line's mode is decided on its first DE cycle, before state has updated
  assign play = de_rise ? (state != S_BLANK && line_ready) : state == S_PLAY;
  assign hit = de_in && play && (in_l || in_r);
  assign seam = col == 11'(HALF_IMG_W - 1) || col == 11'(HALF_IMG_W);
  assign pixel_out = sel[1] ? BORDER_PX : sel[0] ? rd_px : FILL_PX;
  // read-first: the right buffer replays the old line while the new one is stored
  always_ff @(posedge clk) begin
    if (de_in && in_r) begin
      buf_l[wa] <= pixel_left;
      buf_r[wa] <= pixel_right;
    end
    rd_px <= in_l ? buf_l[col[AW-1:0]] : buf_r[wa];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b1;
      sel <= 2'd0;
      col <= '0;
      wr_cnt <= '0;
      line_ready <= 1'b0;
      state <= S_BLANK;
    end else begin
      de_out <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
`ifdef SBS_MERGE_BORDER_EN
      sel <= !hit ? 2'd0 : seam ? 2'd2 : 2'd1;
`else
      sel <= {1'b0, hit};
`endif
      col <= !de_in ? '0 : &col ? col : col + 11'd1;
      if (de_in && in_r) wr_cnt <= wr_cnt + (AW+1)'(1);
      if (de_fall) begin
        line_ready <= wr_cnt == (AW+1)'(HALF_IMG_W);
        wr_cnt <= '0;
      end
      if (vs_fall && state == S_BLANK) state <= S_FILL;
      if (de_rise && state != S_BLANK) state <= line_ready ? S_PLAY : S_FILL;
      if (vs_rise) begin
        state <= S_BLANK;
        line_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sbs_merge.sv
// tb_sbs_merge: random line/frame stimulus checked every cycle against a line-level model of sbs_merge.
module tb_sbs_merge;
  localparam int H = 32;
  localparam int W = 24;
  localparam logic [W-1:0] FILL = '0;
  localparam logic [W-1:0] BORDER = 'hFF;
`ifdef SBS_MERGE_BORDER_EN
  localparam logic [W-1:0] L31 = 'hFF;
  localparam logic [W-1:0] L32 = 'hFF;
`else
  localparam logic [W-1:0] L31 = 'h2F;
  localparam logic [W-1:0] L32 = 'h80;
`endif
  logic clk = 0, rst_n = 0, de_in = 0, h_sync_in = 0, v_sync_in = 1;
  logic [W-1:0] pixel_left = '0, pixel_right = '0, pixel_out;
  logic clk_out, de_out, h_sync_out, v_sync_out;
  int tests = 0, fails = 0;
  logic exp_de = 0, exp_hs = 0, exp_vs = 1;
  logic [W-1:0] exp_px = '0;
  logic [W-1:0] cur_l [H], cur_r [H], prev_l [H], prev_r [H], cap [128];
  bit m_ok = 0, m_play = 0, m_de = 0, m_vs = 1;
  int m_col = 0, ocol = 0;

  sbs_merge #(.HALF_IMG_W(H), .PX_WIDTH(W), .FILL_PX(FILL), .BORDER_PX(BORDER)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_left(pixel_left), .pixel_right(pixel_right), .clk_out(clk_out), .de_out(de_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("clk_out", W'(clk_out), W'(1));
    chk("de_out", W'(de_out), W'(exp_de));
    chk("h_sync_out", W'(h_sync_out), W'(exp_hs));
    chk("v_sync_out", W'(v_sync_out), W'(exp_vs));
    chk("pixel_out", pixel_out, exp_px);
    if (de_out) begin
      if (ocol < 128) cap[ocol] = pixel_out;
      ocol++;
    end else ocol = 0;
  end

  // model: a line is replayed on the next line only if it delivered a full right half
  // and no vertical sync rise or reset came in between
  task automatic cyc(input bit de, input bit hs, input bit vs, input logic [W-1:0] pl,
                     input logic [W-1:0] pr, input bit rst = 0);
    logic [W-1:0] px;
    @(negedge clk);
    rst_n = !rst; de_in = de; h_sync_in = hs; v_sync_in = vs;
    pixel_left = pl; pixel_right = pr;
    if (rst) begin
      m_ok = 0; m_de = 0; m_vs = 1;
      exp_de = 0; exp_hs = 0; exp_vs = 1; exp_px = '0;
      return;
    end
    px = FILL;
    if (de) begin
      if (!m_de) begin m_play = m_ok; m_col = 0; end
      if (m_play && m_col < 2*H) px = m_col < H ? prev_l[m_col] : prev_r[m_col-H];
`ifdef SBS_MERGE_BORDER_EN
      if (m_play && (m_col == H-1 || m_col == H)) px = BORDER;
`endif
      if (m_col >= H && m_col < 2*H) begin cur_l[m_col-H] = pl; cur_r[m_col-H] = pr; end
      m_col++;
    end
    if (!de && m_de) begin
      m_ok = m_col >= 2*H;
      prev_l = cur_l; prev_r = cur_r;
    end
    if (vs && !m_vs) m_ok = 0;
    m_de = de; m_vs = vs;
    exp_de = de; exp_hs = hs; exp_vs = vs; exp_px = px;
  endtask

  task automatic line(input int n, input bit pat = 0, input bit vs_end = 0);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, (pat && i >= H && i < 2*H) ? W'(32'h10 + i - H) : W'($urandom),
                   (pat && i >= H && i < 2*H) ? W'(32'h80 + i - H) : W'($urandom));
    for (int i = 0; i < 4; i++) cyc(0, i < 2, vs_end, W'($urandom), W'($urandom));
  endtask

  task automatic vblank(input int n);
    for (int i = 0; i < n; i++) cyc(0, i == 1, 1, '0, '0);
    for (int i = 0; i < 3; i++) cyc(0, i == 0, 0, '0, '0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 1, '0, '0, 1);
    vblank(4);
    line(64, 1);
    chk("line0_col5_fill", cap[5], FILL);
    line(64, 1);
    chk("line1_col0", cap[0], 'h10);
    chk("line1_col31", cap[31], L31);
    chk("line1_col32", cap[32], L32);
    chk("line1_col63", cap[63], 'h9F);
    line(64, 1);
    line(64);
    line(40);
    line(64);
    chk("after_short_fill", cap[10], FILL);
    line(64);
    line(64, 0, 1);
    vblank(4);
    line(64);
    chk("new_frame_fill", cap[40], FILL);
    line(64); line(64); line(64);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, W'($urandom), W'($urandom));
    cyc(1, 0, 0, W'($urandom), W'($urandom), 1);
    #1;
    chk("reset_de_out", W'(de_out), W'(0));
    chk("reset_v_sync_out", W'(v_sync_out), W'(1));
    for (int i = 0; i < 43; i++) cyc(1, 0, 0, W'($urandom), W'($urandom));
    for (int i = 0; i < 4; i++) cyc(0, i < 2, 0, '0, '0);
    line(64);
    chk("post_reset_fill", cap[50], FILL);
    line(64);
    line(70);
    line(64);
    for (int k = 0; k < 40; k++) begin
      bit ve;
      ve = $urandom_range(0, 7) == 0;
      line($urandom_range(0, 3) == 0 ? $urandom_range(30, 72) : 64, 0, ve);
      if (ve) vblank($urandom_range(2, 5));
    end
    repeat (3) cyc(0, 0, 0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
